// File: rtl/pe_top.sv
// pe_fetch / pe_top: 4-lane 32-bit MAC processing element running a 16-bit program.
// Latency: every instruction takes 2 cycles (FETCH + EXEC); stop rises on the edge ending the HALT EXEC.
// Backpressure: none; valid is only sampled in IDLE/DONE and ignored while a program runs.
//
// pe_fetch ports:
//   clk                          rising-edge clock (memories and IR have no reset)
//   i_pc, i_ir_ld                program counter; load the instruction register from ram_inst[i_pc]
//   o_op, o_fld                  registered opcode (bits 15:12) and operand field (bits 7:0)
//   i_a_addr/o_a_dat, i_b_addr/o_b_dat   combinational reads of matrix A and B words
//   i_res_*                      result memory: combinational read, synchronous write
//   i_ld_*                       generic synchronous load port into A/B/instruction memory
//
// pe_top ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   valid                        start pulse, accepted in IDLE or DONE
//   stop                         high while the program has finished (DONE)

module pe_fetch (
    input  logic         clk,
    input  logic [8:0]   i_pc,
    input  logic         i_ir_ld,
    output logic [3:0]   o_op,
    output logic [7:0]   o_fld,
    input  logic [3:0]   i_a_addr,
    output logic [127:0] o_a_dat,
    input  logic [3:0]   i_b_addr,
    output logic [127:0] o_b_dat,
    input  logic         i_res_we,
    input  logic [3:0]   i_res_addr,
    input  logic [127:0] i_res_wdat,
    output logic [127:0] o_res_rdat,
    input  logic         i_ld_we,
    input  logic [1:0]   i_ld_sel,
    input  logic [8:0]   i_ld_addr,
    input  logic [127:0] i_ld_wdat
);
    logic [127:0] ram_a      [16];
    logic [127:0] ram_b      [16];
    logic [127:0] ram_result [16];
    logic [15:0]  ram_inst   [512];

    logic [3:0]   r_op;
    logic [7:0]   r_fld;

    assign o_a_dat    = ram_a[i_a_addr];
    assign o_b_dat    = ram_b[i_b_addr];
    assign o_res_rdat = ram_result[i_res_addr];
    assign o_op       = r_op;
    assign o_fld      = r_fld;

    // Only the opcode and the low operand byte are kept; bits 11:8 carry no meaning.
    always_ff @(posedge clk) begin
        if (i_ir_ld) begin
            r_op  <= ram_inst[i_pc][15:12];
            r_fld <= ram_inst[i_pc][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (i_res_we) begin
            ram_result[i_res_addr] <= i_res_wdat;
        end
        if (i_ld_we) begin
            case (i_ld_sel)
                2'd0:    ram_a[i_ld_addr[3:0]] <= i_ld_wdat;
                2'd1:    ram_b[i_ld_addr[3:0]] <= i_ld_wdat;
                2'd2:    ram_inst[i_ld_addr]   <= i_ld_wdat[15:0];
                default: ;
            endcase
        end
    end
endmodule

module pe_top (
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    output logic stop
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

    localparam logic [3:0] OP_CLR  = 4'h1;
    localparam logic [3:0] OP_MAC  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t       r_state;
    state_t       w_next;
    logic [8:0]   r_pc;
    logic [31:0]  r_acc [4];

    logic [3:0]   w_op;
    logic [7:0]   w_fld;
    logic [127:0] w_a_dat;
    logic [127:0] w_b_dat;
    logic [127:0] w_res_rdat;
    logic [127:0] w_res_wdat;
    logic         w_res_we;
    logic [31:0]  w_mac [4];
    logic [31:0]  w_sum;

    // The load port is not used by this block; memories are preloaded hierarchically.
    pe_fetch fetch_unit (
        .clk        (clk),
        .i_pc       (r_pc),
        .i_ir_ld    (r_state == S_FETCH),
        .o_op       (w_op),
        .o_fld      (w_fld),
        .i_a_addr   (w_fld[7:4]),
        .o_a_dat    (w_a_dat),
        .i_b_addr   (w_fld[3:0]),
        .o_b_dat    (w_b_dat),
        .i_res_we   (w_res_we),
        .i_res_addr (w_fld[5:2]),      // word 2r + c/4 == {r, c[2]}
        .i_res_wdat (w_res_wdat),
        .o_res_rdat (w_res_rdat),
        .i_ld_we    (1'b0),
        .i_ld_sel   (2'd0),
        .i_ld_addr  (9'd0),
        .i_ld_wdat  ('0)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (valid) w_next = S_FETCH;
            S_FETCH: w_next = S_EXEC;
            S_EXEC:  w_next = (w_op == OP_HALT) ? S_DONE : S_FETCH;
            S_DONE:  if (valid) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    assign stop = (r_state == S_DONE);

    // Lane products are truncated to 32 bits before accumulation.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_mac[l] = r_acc[l] + w_a_dat[32*l +: 32] * w_b_dat[32*l +: 32];
        end
    end

    assign w_sum    = r_acc[0] + r_acc[1] + r_acc[2] + r_acc[3];
    assign w_res_we = (r_state == S_EXEC) && (w_op == OP_STR);

    // Read-modify-write of one 32-bit slot; slot 0 sits in the MSBs, so base = 32*(3-s).
    always_comb begin
        w_res_wdat = w_res_rdat;
        w_res_wdat[{~w_fld[1:0], 5'd0} +: 32] = w_sum;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= '0;
            for (int l = 0; l < 4; l++) r_acc[l] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (valid) r_pc <= '0;
                end
                S_EXEC: begin
                    // 9-bit pc wraps 511 -> 0 naturally; HALT leaves pc where it is.
                    if (w_op != OP_HALT) r_pc <= r_pc + 9'd1;
                    if (w_op == OP_CLR) begin
                        for (int l = 0; l < 4; l++) r_acc[l] <= '0;
                    end else if (w_op == OP_MAC) begin
                        for (int l = 0; l < 4; l++) r_acc[l] <= w_mac[l];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_top.sv
// Testbench for pe_top: random/identity/all-ones matmul against a matrix-level model,
// HALT-at-0 restart timing, pc wrap-around, reset mid-program and in DONE, valid during a run.
// Memories are preloaded and the result read back through the fetch_unit hierarchy.

module tb_pe_top;
    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic valid = 1'b0;
    logic stop;

    int errs   = 0;
    int checks = 0;

    int unsigned mat_a [8][8];
    int unsigned mat_b [8][8];

    pe_top dut (
        .clk   (clk),
        .rstn  (rstn),
        .valid (valid),
        .stop  (stop)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pack the bench matrices into the A/B word layout (element 0 in the LSBs).
    task automatic load_ab();
        logic [127:0] wa, wb;
        for (int w = 0; w < 16; w++) begin
            wa = '0;
            wb = '0;
            for (int s = 0; s < 4; s++) begin
                wa = wa | (128'(mat_a[w/2][4*(w%2)+s]) << (32*s));
                wb = wb | (128'(mat_b[w/2][4*(w%2)+s]) << (32*s));
            end
            dut.fetch_unit.ram_a[w] = wa;
            dut.fetch_unit.ram_b[w] = wb;
        end
        for (int w = 0; w < 16; w++) begin
            dut.fetch_unit.ram_result[w] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic load_matmul();
        logic [15:0] ai, bi;
        for (int a = 0; a < 512; a++) dut.fetch_unit.ram_inst[a] = 16'h0000;
        for (int idx = 0; idx < 64; idx++) begin
            ai = 16'(2 * (idx / 8));
            bi = 16'(2 * (idx % 8));
            dut.fetch_unit.ram_inst[4*idx]   = 16'h1000;
            dut.fetch_unit.ram_inst[4*idx+1] = 16'h2000 | (ai << 4) | bi;
            dut.fetch_unit.ram_inst[4*idx+2] = 16'h2000 | ((ai + 16'd1) << 4) | (bi + 16'd1);
            dut.fetch_unit.ram_inst[4*idx+3] = 16'h3000 | 16'(idx);
        end
        dut.fetch_unit.ram_inst[256] = 16'hF000;
    endtask

    // Result element (r,c): word 2r + c/4, slot c%4 counted from the MSBs.
    function automatic logic [31:0] get_res(input int r, input int c);
        logic [127:0] w;
        w = dut.fetch_unit.ram_result[2*r + c/4];
        w = w >> (32 * (3 - (c % 4)));
        return w[31:0];
    endfunction

    // Pulse valid, then count cycles until stop. glitch>0 pulses valid again at
    // cycle glitch (EXEC when odd) and glitch+49 (FETCH). wrap writes HALT at address 0 mid-run.
    task automatic run(input int glitch, input bit wrap, output int cyc);
        @(negedge clk) valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        cyc = 0;
        while (!stop && cyc < 3000) begin
            if (glitch != 0 && (cyc == glitch || cyc == glitch + 49)) valid = 1'b1;
            if (wrap && cyc == 10) dut.fetch_unit.ram_inst[0] = 16'hF000;
            @(posedge clk);
            #1 valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic check_matmul(input string tag);
        logic [31:0] s;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = 32'd0;
                for (int k = 0; k < 8; k++) s = s + mat_a[i][k] * mat_b[j][k];
                chk($sformatf("%s(%0d,%0d)", tag, i, j), get_res(i, j), s);
            end
        end
    endtask

    task automatic rand_ab();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mat_a[r][c] = $urandom;
                mat_b[r][c] = $urandom;
            end
    endtask

    initial begin
        int cyc;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("rst_stop", {31'd0, stop}, 32'd0);
        chk("rst_pc", 32'(dut.r_pc), 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_stop", {31'd0, stop}, 32'd0);

        // Random matmul, twice
        load_matmul();
        for (int t = 0; t < 2; t++) begin
            rand_ab();
            load_ab();
            run(0, 1'b0, cyc);
            chk($sformatf("rand%0d_cycles", t), 32'(cyc), 32'd514);
            check_matmul($sformatf("rand%0d", t));
            #1 chk($sformatf("rand%0d_stop_held", t), {31'd0, stop}, 32'd1);
        end

        // Identity A: result is the transpose of B
        rand_ab();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mat_a[r][c] = (r == c) ? 32'd1 : 32'd0;
        load_ab();
        run(0, 1'b0, cyc);
        chk("ident_cycles", 32'(cyc), 32'd514);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                chk($sformatf("ident(%0d,%0d)", i, j), get_res(i, j), mat_b[j][i]);

        // All ones: each product is 1 mod 2^32, eight of them
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mat_a[r][c] = 32'hFFFF_FFFF;
                mat_b[r][c] = 32'hFFFF_FFFF;
            end
        load_ab();
        run(0, 1'b0, cyc);
        chk("ones_cycles", 32'(cyc), 32'd514);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                chk($sformatf("ones(%0d,%0d)", i, j), get_res(i, j), 32'd8);

        // HALT at address 0, then restart from DONE
        for (int a = 0; a < 512; a++) dut.fetch_unit.ram_inst[a] = 16'h0000;
        dut.fetch_unit.ram_inst[0] = 16'hF000;
        run(0, 1'b0, cyc);
        chk("halt0_cycles", 32'(cyc), 32'd2);
        @(negedge clk) valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        chk("restart_stop_c0", {31'd0, stop}, 32'd0);
        @(posedge clk);
        #1 chk("restart_stop_c1", {31'd0, stop}, 32'd0);
        @(posedge clk);
        #1 chk("restart_stop_c2", {31'd0, stop}, 32'd1);
        repeat (4) @(posedge clk);
        #1 chk("done_hold", {31'd0, stop}, 32'd1);

        // pc wrap: 512 NOPs, HALT lands at address 0 after the first fetch
        dut.fetch_unit.ram_inst[0] = 16'h0000;
        run(0, 1'b1, cyc);
        chk("wrap_cycles", 32'(cyc), 32'd1026);

        // Reset while in DONE
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk("rst_done_stop", {31'd0, stop}, 32'd0);
        @(negedge clk) rstn = 1'b1;

        // Reset mid-program
        load_matmul();
        rand_ab();
        load_ab();
        @(negedge clk) valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (100) @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk("rst_mid_stop", {31'd0, stop}, 32'd0);
        chk("rst_mid_pc", 32'(dut.r_pc), 32'd0);
        for (int l = 0; l < 4; l++) chk($sformatf("rst_mid_acc%0d", l), dut.r_acc[l], 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (600) @(posedge clk);
        #1 chk("rst_mid_idle", {31'd0, stop}, 32'd0);

        // Rerun after reset, with valid pulsed during EXEC and FETCH
        run(101, 1'b0, cyc);
        chk("rerun_cycles", 32'(cyc), 32'd514);
        check_matmul("rerun");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
